rr_arbiter8: RTL and testbench

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/rr_arbiter8_pkg.sv | 14 +
 rtl/rr_arbiter8_dec.sv | 15 +
 rtl/rr_arbiter8.sv | 86 ++++++++
 tb/tb_rr_arbiter8.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: FSM encoding,
// requester geometry and the default hold limit.
package rr_arbiter8_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_GRANT = 1'b1;

    localparam int NUM_REQ          = 8;
    localparam int IDX_W            = 3;
    localparam int MAX_HOLD_DEFAULT = 16;

endpackage

// File: rtl/rr_arbiter8_dec.sv
// Enabled 3-to-8 one-hot decoder; drives the arbiter grant vector from
// registered owner index and valid flag.
module dec3to8_en (
    input  logic       en,
    input  logic [2:0] idx,
    output logic [7:0] y
);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign y[gi] = en && (idx == 3'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with a one-cycle idle bubble between grants
// and a bounded hold time that revokes a grant after MAX_HOLD cycles.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    state_t     state_reg;
    logic [2:0] ptr_reg;
    logic [2:0] idx_reg;
    logic [7:0] hold_reg;
    logic       timeout_reg;

    logic [2:0] win_idx;
    logic [2:0] cand;
    logic       owner_req;
    logic       expire;
    logic       release_now;

    // Scan downward in offset so the lowest offset from ptr is the last
    // assignment and therefore wins.
    always_comb begin
        win_idx = ptr_reg;
        cand    = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = ptr_reg + 3'(off);
            if (req[cand]) begin
                win_idx = cand;
            end
        end
    end

    assign owner_req   = req[idx_reg];
    assign expire      = (hold_reg == 8'(MAX_HOLD - 1));
    assign release_now = done || !owner_req || expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            ptr_reg     <= '0;
            idx_reg     <= '0;
            hold_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            if (state_reg == ST_IDLE) begin
                if (en && (req != '0)) begin
                    state_reg <= ST_GRANT;
                    idx_reg   <= win_idx;
                    hold_reg  <= '0;
                end
            end else begin
                if (release_now) begin
                    state_reg   <= ST_IDLE;
                    ptr_reg     <= idx_reg + 3'd1;
                    // A coincident done or dropped request makes this a normal release.
                    timeout_reg <= expire && !done && owner_req;
                end else begin
                    hold_reg <= hold_reg + 8'd1;
                end
            end
        end
    end

    assign grant_valid = (state_reg == ST_GRANT);
    assign grant_idx   = idx_reg;
    assign timeout     = timeout_reg;

    dec3to8_en u_dec (
        .en  (grant_valid),
        .idx (idx_reg),
        .y   (grant)
    );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_rr_arbiter8;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    rr_arbiter8 #(.MAX_HOLD(HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    // Behavioural model: owner (-1 when idle), next search start, cycles the
    // current owner has held the grant so far, and the pending timeout pulse.
    int m_owner = -1;
    int m_ptr = 0;
    int m_held = 0;
    bit m_to = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                if (en && req != 8'h00) begin
                    for (int k = 7; k >= 0; k--) begin
                        if (req[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
                    end
                    m_held = 1;
                end
            end else begin
                if (done || !req[m_owner] || m_held == HOLD) begin
                    m_to    = (m_held == HOLD) && !done && req[m_owner];
                    m_ptr   = (m_owner + 1) % 8;
                    m_owner = -1;
                end else begin
                    m_held++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic [7:0] exp_g;
            exp_g = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
            checks++;
            if (grant !== exp_g) begin
                failures++;
                $display("FAIL model_grant t=%0t got=%h want=%h", $time, grant, exp_g);
            end
            checks++;
            if (grant_valid !== (m_owner >= 0)) begin
                failures++;
                $display("FAIL model_valid t=%0t got=%b want=%b", $time, grant_valid, (m_owner >= 0));
            end
            checks++;
            if (timeout !== m_to) begin
                failures++;
                $display("FAIL model_timeout t=%0t got=%b want=%b", $time, timeout, m_to);
            end
            if (m_owner >= 0) begin
                checks++;
                if (grant_idx !== 3'(m_owner)) begin
                    failures++;
                    $display("FAIL model_idx t=%0t got=%0d want=%0d", $time, grant_idx, m_owner);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    initial begin
        // Reset, then an idle stretch with no requests.
        tick();
        chk_on = 1'b1;
        tick();
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            lit("idle_grant", grant, 8'h00);
            lit("idle_timeout", {7'd0, timeout}, 8'h00);
        end

        // Rotation over all eight requesters, done one cycle after each grant.
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            lit("rot_grant", grant, 8'(1 << (i % 8)));
            done = 1'b1;
            tick();
            done = 1'b0;
            lit("rot_bubble", grant, 8'h00);
            if (i == 8) req = 8'h00;
        end

        // Wrap: owner 6 leaves ptr at 7, then req=05 picks 0 before 2.
        req = 8'h40;
        tick();
        lit("wrap_g6", grant, 8'h40);
        done = 1'b1;
        req  = 8'h05;
        tick();
        done = 1'b0;
        tick();
        lit("wrap_g0", grant, 8'h01);
        lit("wrap_idx0", {5'd0, grant_idx}, 8'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        lit("wrap_g2", grant, 8'h04);
        lit("wrap_idx2", {5'd0, grant_idx}, 8'd2);
        done = 1'b1;
        req  = 8'h00;
        tick();
        done = 1'b0;
        tick();

        // Hold expiry with a single persistent requester.
        req = 8'h08;
        tick();
        for (int k = 0; k < HOLD; k++) begin
            lit("to_hold", grant, 8'h08);
            tick();
        end
        lit("to_bubble", grant, 8'h00);
        lit("to_pulse", {7'd0, timeout}, 8'h01);
        tick();
        lit("to_regrant", grant, 8'h08);
        lit("to_pulse_end", {7'd0, timeout}, 8'h00);
        tick();
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        lit("to_done_bubble", grant, 8'h00);
        lit("to_done_nopulse", {7'd0, timeout}, 8'h00);
        req = 8'h00;
        tick();

        // Enable gating, hold under en=0, and asynchronous reset mid-grant.
        en  = 1'b0;
        req = 8'h10;
        for (int k = 0; k < 3; k++) begin
            tick();
            lit("en_block", grant, 8'h00);
        end
        en = 1'b1;
        tick();
        lit("en_grant", grant, 8'h10);
        en = 1'b0;
        tick();
        lit("en_hold", grant, 8'h10);
        #2;
        rst = 1'b1;
        #1;
        lit("rst_async_grant", grant, 8'h00);
        lit("rst_async_valid", {7'd0, grant_valid}, 8'h00);
        tick();
        rst = 1'b0;
        en  = 1'b1;
        req = 8'h11;
        tick();
        lit("rst_ptr0", grant, 8'h01);
        done = 1'b1;
        req  = 8'h00;
        tick();
        done = 1'b0;

        // Randomized traffic, checked every cycle by the model comparator.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) != 0) req = 8'($urandom);
            if ($urandom_range(0, 3) == 0) req = 8'(1 << $urandom_range(0, 7));
            en   = ($urandom_range(0, 9) != 0);
            done = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2;
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
